// File: rtl/dbl_framebuf_if.sv
// rtl/dbl_framebuf_if.sv - core write, frame/video timing and status bundle for dbl_framebuf
// master : the core / video-timing side (drives pixels, frame, timing; sees colour and status)
// slave  : the frame buffer (consumes pixels and timing; drives colour and status)
interface dbl_framebuf_if;
   logic       ce_pix;
   logic       wr_valid;
   logic [7:0] wr_x;
   logic [7:0] wr_y;
   logic [7:0] wr_rgb;
   logic       frame;
   logic       vblank;
   logic       de;
   logic [8:0] hcount;
   logic [8:0] vcount;
   logic [7:0] r_out;
   logic [7:0] g_out;
   logic [7:0] b_out;
   logic       disp_bank;
   logic       swap_pending;
   logic       clearing;
   logic [7:0] frames_shown;
   logic [7:0] frames_dropped;

   modport master (
      output ce_pix, wr_valid, wr_x, wr_y, wr_rgb, frame, vblank, de, hcount, vcount,
      input  r_out, g_out, b_out, disp_bank, swap_pending, clearing, frames_shown, frames_dropped
   );

   modport slave (
      input  ce_pix, wr_valid, wr_x, wr_y, wr_rgb, frame, vblank, de, hcount, vcount,
      output r_out, g_out, b_out, disp_bank, swap_pending, clearing, frames_shown, frames_dropped
   );
endinterface

// File: rtl/dbl_framebuf.sv
// rtl/dbl_framebuf.sv - double-buffered 256x256 RGB332 frame buffer with vblank swap and back-bank clear
// clk_sys : single system clock
// reset   : asynchronous active-high reset (bank contents are not reset)
// bus     : core pixel writes (wr_*), frame level, video timing (ce_pix/de/hcount/vcount/vblank),
//           expanded colour out (r/g/b_out) and status (disp_bank, swap_pending, clearing,
//           frames_shown, frames_dropped)
module dbl_framebuf #(
   parameter int CLEAR_EN = 1
) (
   input  logic          clk_sys,
   input  logic          reset,
   dbl_framebuf_if.slave bus
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t      state;
   logic        frame_q;
   logic        vblank_q;
   logic        disp_bank;
   logic        swap_pending;
   logic        clearing;
   logic [15:0] clear_addr;
   logic [7:0]  frames_shown;
   logic [7:0]  frames_dropped;

   logic        frame_rise;
   logic        vb_rise;
   logic        do_swap;

   // both banks share one array; the MSB of the address selects the bank
   logic [7:0]  mem [0:131071];
   logic        mem_we;
   logic [16:0] mem_waddr;
   logic [7:0]  mem_wdata;

   logic [16:0] rd_addr;
   logic        in_range;
   logic [7:0]  rd_data;
   logic        rd_stb;
   logic        rd_blank;
   logic [7:0]  r_q;
   logic [7:0]  g_q;
   logic [7:0]  b_q;

   assign frame_rise = bus.frame & ~frame_q;
   assign vb_rise    = bus.vblank & ~vblank_q;
   // a frame finishing on the very vblank edge is swapped in directly, never counted as dropped
   assign do_swap    = (state == ST_IDLE) && vb_rise && (swap_pending || frame_rise);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         frame_q        <= 1'b0;
         vblank_q       <= 1'b0;
         disp_bank      <= 1'b0;
         swap_pending   <= 1'b0;
         clearing       <= 1'b0;
         clear_addr     <= '0;
         frames_shown   <= '0;
         frames_dropped <= '0;
      end else begin
         frame_q  <= bus.frame;
         vblank_q <= bus.vblank;

         if (do_swap) begin
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
            frames_shown <= frames_shown + 8'd1;
            if (CLEAR_EN != 0) begin
               state      <= ST_CLEAR;
               clearing   <= 1'b1;
               clear_addr <= '0;
            end
         end else if (frame_rise) begin
            if (swap_pending) begin
               if (frames_dropped != 8'hFF)
                  frames_dropped <= frames_dropped + 8'd1;
            end else begin
               swap_pending <= 1'b1;
            end
         end

         // a core write owns the memory port this cycle, so the clear pointer stalls
         if (state == ST_CLEAR && !bus.wr_valid) begin
            clear_addr <= clear_addr + 16'd1;
            if (clear_addr == 16'hFFFF) begin
               state    <= ST_IDLE;
               clearing <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (bus.wr_valid) begin
         mem_we    = 1'b1;
         mem_waddr = {~disp_bank, bus.wr_y, bus.wr_x};
         mem_wdata = bus.wr_rgb;
      end else if (state == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = {~disp_bank, clear_addr};
      end
   end

   // writes always target the back bank and reads the front bank, so they never collide
   assign in_range = bus.de & ~bus.hcount[8] & ~bus.vcount[8];
   assign rd_addr  = {disp_bank, bus.vcount[7:0], bus.hcount[7:0]};

   always_ff @(posedge clk_sys) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
      if (bus.ce_pix)
         rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_stb   <= 1'b0;
         rd_blank <= 1'b0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
      end else begin
         rd_stb <= bus.ce_pix;
         if (bus.ce_pix)
            rd_blank <= ~in_range;
         if (rd_stb) begin
            if (rd_blank) begin
               r_q <= '0;
               g_q <= '0;
               b_q <= '0;
            end else begin
               // replicate the short fields so full-scale codes map to 0xFF
               r_q <= {rd_data[7:5], rd_data[7:5], rd_data[7:6]};
               g_q <= {rd_data[4:2], rd_data[4:2], rd_data[4:3]};
               b_q <= {4{rd_data[1:0]}};
            end
         end
      end
   end

   assign bus.r_out          = r_q;
   assign bus.g_out          = g_q;
   assign bus.b_out          = b_q;
   assign bus.disp_bank      = disp_bank;
   assign bus.swap_pending   = swap_pending;
   assign bus.clearing       = clearing;
   assign bus.frames_shown   = frames_shown;
   assign bus.frames_dropped = frames_dropped;

endmodule
